// File: rtl/lsu_store_encoder.sv
// lsu_store_encoder
//   Converts a core store request (byte/halfword/word, right-aligned data)
//   into a single AHB-Lite NONSEQ write. Data is replicated onto the byte
//   lanes and byte enables are derived from the low address bits.
//   Misaligned or invalid-size requests are rejected without touching the bus.
//
// Ports
//   s_clk_i, s_reset_i          clock, asynchronous active-high reset
//   s_req_i / s_ready_o         request handshake (ready only in IDLE)
//   s_addr_i, s_wdata_i, s_size_i  store address, data, size
//   s_haddr_o .. s_hwdata_o     AHB-Lite master outputs
//   s_hready_i, s_hresp_i       AHB-Lite slave response
//   s_be_o                      byte enables of the transfer in flight
//   s_done_o, s_err_o, s_mis_o  one-cycle completion/status pulses
module lsu_store_encoder (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_req_i,
  output logic        s_ready_o,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_wdata_i,
  input  logic [1:0]  s_size_i,
  output logic [31:0] s_haddr_o,
  output logic [1:0]  s_htrans_o,
  output logic        s_hwrite_o,
  output logic [2:0]  s_hsize_o,
  output logic [31:0] s_hwdata_o,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  output logic [3:0]  s_be_o,
  output logic        s_done_o,
  output logic        s_err_o,
  output logic        s_mis_o
);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic [3:0]  r_be;
  logic        r_done;
  logic        r_err;
  logic        r_mis;

  logic        w_accept;
  logic        w_mis;
  logic [31:0] w_enc_data;
  logic [3:0]  w_enc_be;
  logic        w_done_next;
  logic        w_err_next;

  // Reset also blocks acceptance so nothing is captured while held in reset.
  assign w_accept = s_req_i & (r_state == StIdle) & ~s_reset_i;

  // Alignment check, lane replication and byte enables for the incoming request.
  always_comb begin
    w_mis      = 1'b0;
    w_enc_data = s_wdata_i;
    w_enc_be   = 4'b1111;
    unique case (s_size_i)
      2'b00: begin
        w_mis      = 1'b0;
        w_enc_data = {4{s_wdata_i[7:0]}};
        w_enc_be   = 4'b0001 << s_addr_i[1:0];
      end
      2'b01: begin
        w_mis      = s_addr_i[0];
        w_enc_data = {2{s_wdata_i[15:0]}};
        w_enc_be   = 4'b0011 << {s_addr_i[1], 1'b0};
      end
      2'b10: begin
        w_mis      = |s_addr_i[1:0];
        w_enc_data = s_wdata_i;
        w_enc_be   = 4'b1111;
      end
      2'b11: begin
        w_mis      = 1'b1;
        w_enc_data = s_wdata_i;
        w_enc_be   = 4'b0000;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept && !w_mis) begin
          w_state_next = StAddr;
        end
      end
      StAddr: begin
        if (s_hready_i) begin
          w_state_next = StData;
        end
      end
      StData: begin
        // hresp with hready low is the first error-response cycle; ignore it.
        if (s_hready_i) begin
          w_state_next = StIdle;
          w_done_next  = ~s_hresp_i;
          w_err_next   = s_hresp_i;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_state <= StIdle;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_size  <= 2'b00;
      r_be    <= 4'h0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      r_mis   <= w_accept & w_mis;
      if (w_accept) begin
        r_addr <= s_addr_i;
        r_data <= w_enc_data;
        r_size <= s_size_i;
        r_be   <= w_enc_be;
      end
    end
  end

  // Outputs are decoded from state so an asynchronous reset clears them at once.
  always_comb begin
    s_ready_o  = (r_state == StIdle);
    s_htrans_o = HtransIdle;
    s_hwrite_o = 1'b0;
    s_haddr_o  = 32'h0;
    s_hsize_o  = 3'b000;
    s_hwdata_o = 32'h0;
    s_be_o     = 4'h0;
    if (r_state == StAddr) begin
      s_htrans_o = HtransNonseq;
      s_hwrite_o = 1'b1;
      s_haddr_o  = r_addr;
      s_hsize_o  = {1'b0, r_size};
      s_be_o     = r_be;
    end
    if (r_state == StData) begin
      s_hwdata_o = r_data;
      s_be_o     = r_be;
    end
  end

  assign s_done_o = r_done;
  assign s_err_o  = r_err;
  assign s_mis_o  = r_mis;

endmodule

// File: doc/lsu_store_encoder.md
LSU_STORE_ENCODER -- requirements
Module: lsu_store_encoder

Interface
REQ-001 The block SHALL expose these ports:
- s_clk_i  in  1  core clock; all state changes on its rising edge.
- s_reset_i  in  1  asynchronous, active-high reset.
- s_req_i  in  1  store request valid.
- s_ready_o  out  1  block can accept a request.
- s_addr_i  in  32  byte address of the store.
- s_wdata_i  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- s_size_i  in  2  00 byte, 01 halfword, 10 word, 11 invalid.
- s_haddr_o  out  32  AHB-Lite address.
- s_htrans_o  out  2  AHB-Lite transfer type: 00 IDLE, 10 NONSEQ.
- s_hwrite_o  out  1  AHB-Lite write.
- s_hsize_o  out  3  AHB-Lite size: 000, 001 or 010.
- s_hwdata_o  out  32  AHB-Lite write data, lane-aligned.
- s_hready_i  in  1  AHB-Lite transfer ready.
- s_hresp_i  in  1  AHB-Lite error response.
- s_be_o  out  4  byte-lane enables of the current transfer (informative).
- s_done_o  out  1  one-cycle pulse: store completed without error.
- s_err_o  out  1  one-cycle pulse: bus error response.
- s_mis_o  out  1  one-cycle pulse: misaligned or invalid-size request rejected.
REQ-002 Clock and reset SHALL be exactly one clock, s_clk_i, and one asynchronous, active-high reset, s_reset_i.

Function
REQ-003 The FSM SHALL have three states: IDLE, ADDR and DATA. s_ready_o SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted when s_req_i and s_ready_o are both 1. On acceptance, address, encoded data, size and byte enables SHALL be captured into registers.
REQ-005 Misalignment SHALL be checked on acceptance:
- halfword with addr[0]=1 is misaligned;
- word with addr[1:0]!=00 is misaligned;
- size 11 is invalid.
REQ-006 A misaligned or invalid request SHALL NOT start a bus transfer. The FSM SHALL stay in IDLE and assert s_mis_o for exactly the cycle after acceptance.
REQ-007 An aligned request SHALL move the FSM to ADDR on the next cycle.
REQ-008 Data encoding SHALL be:
- byte: wdata[7:0] replicated on all four lanes;
- halfword: wdata[15:0] replicated on both halves;
- word: wdata unchanged.
REQ-009 Byte enables SHALL be:
- byte: 4'b0001 shifted left by addr[1:0];
- halfword: 4'b0011 shifted left by 2*addr[1];
- word: 4'b1111.
REQ-010 In ADDR the block SHALL drive htrans=10, hwrite=1, haddr = captured address, hsize = {0,size}.
REQ-011 The FSM SHALL hold ADDR while hready=0 and move to DATA on the cycle hready=1.
REQ-012 In DATA the block SHALL drive htrans=00 and hwdata = captured encoded data, held stable until the transfer completes.
REQ-013 In DATA the block SHALL complete on the cycle hready=1:
- hresp=0: s_done_o pulses on the next cycle and the FSM returns to IDLE;
- hresp=1: s_err_o pulses on the next cycle and the FSM returns to IDLE.
REQ-014 In DATA, hresp=1 with hready=0 (first cycle of the error response) SHALL be ignored.
REQ-015 Outside ADDR, htrans SHALL be 00, hwrite 0, haddr 0 and hsize 000. hwdata SHALL be 0 outside DATA.
REQ-016 s_done_o, s_err_o and s_mis_o SHALL be mutually exclusive, and each SHALL last exactly one cycle.
REQ-017 Latency from acceptance to s_done_o SHALL be 3 cycles with zero wait states, plus one cycle per hready=0 cycle in ADDR or DATA.
REQ-018 Back-to-back stores SHALL be supported: a new request may be accepted in the cycle s_done_o or s_err_o is high. Throughput SHALL be at most one store per 3 cycles.

Reset
REQ-019 While s_reset_i=1 the FSM SHALL be IDLE and these outputs SHALL be 0: htrans, hwrite, haddr, hsize, hwdata, s_be_o, s_done_o, s_err_o, s_mis_o.
REQ-020 s_ready_o SHALL be 1 during reset.
REQ-021 Reset asserted mid-transfer (ADDR or DATA) SHALL abort immediately with no done or error pulse. No request SHALL be accepted while s_reset_i=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Byte store, addr=0x1003, wdata=0x000000A5, hready=1 -> ADDR cycle with haddr=0x1003, hsize=000; DATA cycle with hwdata=0xA5A5A5A5, be=1000; s_done_o 3 cycles after accept.
- Halfword store, addr=0x2002, wdata=0x0000BEEF, hready low 2 cycles in ADDR -> hwdata=0xBEEFBEEF, be=1100, s_done_o 5 cycles after accept.
- Word store, addr=0x3001 -> no htrans activity; s_mis_o pulses 1 cycle after accept. Same with size=11 at addr=0x3000.
- Word store, addr=0x4000, DATA phase: hready=0/hresp=1 then hready=1/hresp=1 -> s_err_o pulse, no s_done_o, FSM back to IDLE.
- Reset asserted during DATA with hready=0 -> all outputs 0 in the same cycle, s_ready_o=1, no pulse; next store completes normally.
- Two consecutive word stores with s_req_i held high -> second accepted in the s_done_o cycle, NONSEQ every 3 cycles.
